// File: rtl/hdmi_tmds_pkg.sv
// Shared constants and state encoding for the HDMI TMDS output path.
package hdmi_tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00     = 10'b1101010100;
  localparam logic [9:0] TMDS_CLK_PATTERN = 10'b0000011111;

  localparam logic [2:0] PHASE_LOAD = 3'd2;
  localparam logic [2:0] PHASE_LAST = 3'd4;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'b001,
    SETTLE    = 3'b010,
    RUN       = 3'b100
  } seq_state_e;

endpackage

// File: rtl/tmds_ddr_shifter.sv
// 10-bit TMDS word serialiser: emits two bits per clk_x5 cycle, LSB first,
// with the earlier bit in pair_o[1] (rising-edge DDR data).
module tmds_ddr_shifter (
  input  logic       clk_x5,
  input  logic       reset,
  input  logic       load_i,
  input  logic [9:0] word_i,
  output logic [1:0] pair_o
);

  logic [7:0] rest_q;
  logic [1:0] pair_q;

  // The first pair is registered straight from the load word so it appears
  // one cycle after the capture edge; the remaining eight bits queue behind it.
  always_ff @(posedge clk_x5) begin
    if (reset) begin
      rest_q <= '0;
      pair_q <= '0;
    end else if (load_i) begin
      pair_q <= {word_i[0], word_i[1]};
      rest_q <= word_i[9:2];
    end else begin
      pair_q <= {rest_q[0], rest_q[1]};
      rest_q <= {2'b00, rest_q[7:2]};
    end
  end

  assign pair_o = pair_q;

endmodule

// File: rtl/tmds_ddr_sequencer.sv
// clk_x5-domain HDMI output sequencer: pixel clock generation, PLL-lock
// bring-up FSM, idle-symbol substitution and four DDR lane serialisers.
module tmds_ddr_sequencer
  import hdmi_tmds_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_x5,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic [9:0]       tmds_red,
  input  logic [9:0]       tmds_green,
  input  logic [9:0]       tmds_blue,
  output logic             pclk,
  output logic             video_rst,
  output logic             running,
  output logic [1:0]       out_tmds_red,
  output logic [1:0]       out_tmds_green,
  output logic [1:0]       out_tmds_blue,
  output logic [1:0]       out_tmds_clk,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [2:0]       phase_q, phase_d;
  logic             pclk_q;
  logic             lock_meta_q, lock_s_q;
  seq_state_e       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             video_rst_q;

  assign phase_d = (phase_q == PHASE_LAST) ? 3'd0 : phase_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    loss_d   = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        settle_d = '0;
        if (lock_s_q) state_d = SETTLE;
      end
      SETTLE: begin
        // Lock loss wins over a settle count completing in the same cycle.
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end else begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_x5) begin
    if (reset) begin
      phase_q     <= '0;
      pclk_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      settle_q    <= '0;
      loss_q      <= '0;
      video_rst_q <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      pclk_q      <= (phase_d == 3'd0) || (phase_d == 3'd1);
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      settle_q    <= settle_d;
      loss_q      <= loss_d;
      video_rst_q <= (state_d != RUN);
    end
  end

  // Substitution is decided at capture time, so a word already in flight
  // always completes and no truncated symbol reaches the pins.
  logic       load;
  logic       is_run;
  logic [9:0] red_w, green_w, blue_w, clk_w;

  assign load    = (phase_q == PHASE_LOAD);
  assign is_run  = (state_q == RUN);
  assign red_w   = is_run ? tmds_red   : TMDS_CTRL_00;
  assign green_w = is_run ? tmds_green : TMDS_CTRL_00;
  assign blue_w  = is_run ? tmds_blue  : TMDS_CTRL_00;
  assign clk_w   = (state_q == WAIT_LOCK) ? 10'd0 : TMDS_CLK_PATTERN;

  tmds_ddr_shifter u_red   (.clk_x5(clk_x5), .reset(reset), .load_i(load), .word_i(red_w),   .pair_o(out_tmds_red));
  tmds_ddr_shifter u_green (.clk_x5(clk_x5), .reset(reset), .load_i(load), .word_i(green_w), .pair_o(out_tmds_green));
  tmds_ddr_shifter u_blue  (.clk_x5(clk_x5), .reset(reset), .load_i(load), .word_i(blue_w),  .pair_o(out_tmds_blue));
  tmds_ddr_shifter u_clk   (.clk_x5(clk_x5), .reset(reset), .load_i(load), .word_i(clk_w),   .pair_o(out_tmds_clk));

  assign pclk          = pclk_q;
  assign video_rst     = video_rst_q;
  assign running       = ~video_rst_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_tmds_ddr_sequencer.sv
// Scoreboard bench for tmds_ddr_sequencer: expected 5-pair lane streams are
// queued at capture time and compared by a frame monitor on the falling edge.
module tb_tmds_ddr_sequencer;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned CW     = 8;

  // Pair streams written as {p0,p1,p2,p3,p4}, p0 first on the wire.
  localparam logic [9:0] CTRL_S = 10'b00_10_10_10_11; // 1101010100
  localparam logic [9:0] CLK_S  = 10'b11_11_10_00_00; // 0000011111
  localparam logic [9:0] RED0_S = 10'b00_11_10_01_01; // 1010011100

  logic          clk_x5 = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic [9:0]    tmds_red, tmds_green, tmds_blue;
  logic          pclk, video_rst, running;
  logic [1:0]    out_tmds_red, out_tmds_green, out_tmds_blue, out_tmds_clk;
  logic [CW-1:0] lock_loss_cnt;

  always #5 clk_x5 = ~clk_x5;

  tmds_ddr_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk_x5(clk_x5), .reset(reset), .pll_locked(pll_locked),
    .tmds_red(tmds_red), .tmds_green(tmds_green), .tmds_blue(tmds_blue),
    .pclk(pclk), .video_rst(video_rst), .running(running),
    .out_tmds_red(out_tmds_red), .out_tmds_green(out_tmds_green),
    .out_tmds_blue(out_tmds_blue), .out_tmds_clk(out_tmds_clk),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [9:0] r, g, b, c;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [9:0] stream_of(input logic [9:0] w);
    logic [9:0] s;
    for (int k = 0; k < 5; k++) begin
      s[9-2*k] = w[2*k];
      s[8-2*k] = w[2*k+1];
    end
    return s;
  endfunction

  // Frame monitor: a frame starts on the second low pclk sample after a high one.
  logic [2:0] ph_hist = '0;
  bit         act     = 1'b0;
  int         npair   = 0;
  exp_t       cur;
  logic [9:0] gr, gg, gb, gc;

  always @(negedge clk_x5) begin
    ph_hist = {ph_hist[1:0], pclk};
    if (!act && ph_hist == 3'b100 && sbq.size() > 0) begin
      cur   = sbq.pop_front();
      act   = 1'b1;
      npair = 0;
    end
    if (act) begin
      gr = {gr[7:0], out_tmds_red};
      gg = {gg[7:0], out_tmds_green};
      gb = {gb[7:0], out_tmds_blue};
      gc = {gc[7:0], out_tmds_clk};
      npair++;
      if (npair == 5) begin
        chk({cur.tag, "/red"},   32'(gr), 32'(cur.r));
        chk({cur.tag, "/green"}, 32'(gg), 32'(cur.g));
        chk({cur.tag, "/blue"},  32'(gb), 32'(cur.b));
        chk({cur.tag, "/clk"},   32'(gc), 32'(cur.c));
        act = 1'b0;
      end
    end
  end

  task automatic wait_capture(output bit ok);
    bit prev;
    prev = pclk;
    ok   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_x5); #1;
      if (prev && !pclk) begin
        ok = 1'b1;
        break;
      end
      prev = pclk;
    end
    if (!ok) chk("capture_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_frame(input string tag, input logic [9:0] r, input logic [9:0] g,
                              input logic [9:0] b, input logic [9:0] c);
    bit ok;
    wait_capture(ok);
    if (ok) sbq.push_back('{tag, r, g, b, c});
    @(posedge clk_x5); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit pushed;
    bit prev;
    int rise;
    logic vr_at_rise;
    logic smp[50];
    int p2;

    reset = 1'b1; pll_locked = 1'b0;
    tmds_red = '0; tmds_green = '0; tmds_blue = '0;
    repeat (3) @(posedge clk_x5);
    #1;
    chk("rst_pclk", 32'(pclk), 32'd0);
    chk("rst_video_rst", 32'(video_rst), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_outs", 32'({out_tmds_red, out_tmds_green, out_tmds_blue, out_tmds_clk}), 32'd0);
    chk("rst_loss", 32'(lock_loss_cnt), 32'd0);

    // WAIT_LOCK: data lanes idle, clock lane silent.
    tmds_red = 10'h3FF; tmds_green = 10'h000; tmds_blue = 10'h155;
    reset = 1'b0;
    expect_frame("wait", CTRL_S, CTRL_S, CTRL_S, 10'd0);

    // Lock and settle, with one SETTLE-state capture along the way.
    tmds_blue  = 10'h3FF;
    pll_locked = 1'b1;
    pushed = 1'b0; rise = 0; vr_at_rise = 1'bx;
    prev = pclk;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk_x5); #1;
      if (!pushed && n >= 6 && prev && !pclk) begin
        sbq.push_back('{"settle", CTRL_S, CTRL_S, CTRL_S, CLK_S});
        pushed = 1'b1;
      end
      prev = pclk;
      if (running && rise == 0) begin
        rise = n;
        vr_at_rise = video_rst;
      end
    end
    chk("run_rise_cycles", 32'(rise), 32'd19);
    chk("vrst_at_rise", 32'(vr_at_rise), 32'd0);
    chk("loss_after_lock", 32'(lock_loss_cnt), 32'd0);

    // pclk shape: high in phases 0,1; a fall marks phase 2.
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_x5); #1;
      smp[i] = pclk;
    end
    p2 = -1;
    for (int i = 1; i < 50; i++)
      if (p2 < 0 && smp[i-1] && !smp[i]) p2 = i;
    if (p2 < 0) chk("pclk_no_fall", 32'd0, 32'd1);
    else
      for (int i = 0; i < 50; i++)
        chk("pclk_shape", 32'(smp[i]), 32'((((i - p2) % 5 + 7) % 5) < 2));

    // RUN serialisation.
    tmds_red = 10'b1010011100; tmds_green = 10'h2C3; tmds_blue = 10'h0F0;
    expect_frame("run0", RED0_S, stream_of(10'h2C3), stream_of(10'h0F0), CLK_S);
    tmds_red = 10'h155; tmds_green = 10'h3FF; tmds_blue = 10'h000;
    expect_frame("run1", stream_of(10'h155), stream_of(10'h3FF), 10'd0, CLK_S);

    // Lock drop at phase 4 while a RUN word is on the wire.
    tmds_red = 10'h2A5; tmds_green = 10'h10F; tmds_blue = 10'h3C0;
    wait_capture(ok);
    if (ok) sbq.push_back('{"pre_drop", stream_of(10'h2A5), stream_of(10'h10F), stream_of(10'h3C0), CLK_S});
    @(posedge clk_x5); #1;
    @(posedge clk_x5); #1;
    pll_locked = 1'b0;
    @(posedge clk_x5); #1;
    chk("drop_vrst_1", 32'(video_rst), 32'd0);
    @(posedge clk_x5); #1;
    chk("drop_vrst_2", 32'(video_rst), 32'd0);
    @(posedge clk_x5); #1;
    chk("drop_vrst_3", 32'(video_rst), 32'd1);
    chk("drop_running", 32'(running), 32'd0);
    chk("drop_loss", 32'(lock_loss_cnt), 32'd1);
    sbq.push_back('{"post_drop", CTRL_S, CTRL_S, CTRL_S, 10'd0});
    repeat (12) @(posedge clk_x5);
    #1;

    // Saturation of the lock-loss counter.
    for (int p = 1; p <= 300; p++) begin
      pll_locked = 1'b1;
      repeat (3) @(posedge clk_x5);
      #1;
      pll_locked = 1'b0;
      repeat (3) @(posedge clk_x5);
      #1;
      if (p == 253) chk("loss_pre_sat", 32'(lock_loss_cnt), 32'd254);
      if (p == 254) chk("loss_reach_sat", 32'(lock_loss_cnt), 32'd255);
    end
    repeat (6) @(posedge clk_x5);
    #1;
    chk("loss_saturated", 32'(lock_loss_cnt), 32'd255);
    chk("sat_vrst", 32'(video_rst), 32'd1);

    // Reset in the middle of a word.
    repeat (2) @(posedge clk_x5);
    #1;
    reset = 1'b1;
    @(posedge clk_x5); #1;
    chk("midrst_outs", 32'({out_tmds_red, out_tmds_green, out_tmds_blue, out_tmds_clk}), 32'd0);
    chk("midrst_pclk", 32'(pclk), 32'd0);
    chk("midrst_loss", 32'(lock_loss_cnt), 32'd0);
    chk("midrst_vrst", 32'(video_rst), 32'd1);
    reset = 1'b0;

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("sb_idle", 32'(act), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
